// File: rtl/alloc_pkg.sv
// Shared definitions for the output-port allocator: default port count,
// FSM state type and one-hot select width.
package alloc_pkg;

  localparam int N_IN_DEFAULT = 6;
  localparam int ONEHOT_W     = N_IN_DEFAULT;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of an index into N ports; at least one bit so a 1-port build still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted req at or above ptr,
// wrapping past the top port, returned as a one-hot winner.
module rr_arbiter
  import alloc_pkg::*;
#(
  parameter int N_IN  = N_IN_DEFAULT,
  parameter int PTR_W = ptr_width(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_IN-1:0]  winner
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_IN; k++) begin
      // Offset k from ptr, folded back into 0..N_IN-1.
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N_IN)) begin
        sum = sum - (PTR_W + 1)'(N_IN);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_allocator_6.sv
// Wormhole output-port allocator: locks the output to one input for a whole
// packet. Optional macro ALLOC_BACK2BACK_EN re-arbitrates on the tail cycle.
module output_allocator_6
  import alloc_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] valid_in,
  input  logic [N_IN-1:0] tail_in,
  input  logic            out_stall,
  output logic [N_IN-1:0] mux_sel,
  output logic [N_IN-1:0] grant,
  output logic            valid_out
);

  localparam int PTR_W = ptr_width(N_IN);

  state_t           state, state_nx;
  logic [PTR_W-1:0] ptr, ptr_nx;
  logic [PTR_W-1:0] owner_idx, rel_ptr, arb_ptr;
  logic [N_IN-1:0]  mux_sel_nx, arb_gnt, grant_c;

  // Owner index recovered from the one-hot select register.
  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (mux_sel[k]) begin
        owner_idx = PTR_W'(k);
      end
    end
  end

  assign rel_ptr = (owner_idx == PTR_W'(N_IN - 1)) ? '0 : owner_idx + PTR_W'(1);

`ifdef ALLOC_BACK2BACK_EN
  // On a tail transfer the search must already start past the releasing owner.
  assign arb_ptr = (state == LOCKED) ? rel_ptr : ptr;
`else
  assign arb_ptr = ptr;
`endif

  rr_arbiter #(
    .N_IN  (N_IN),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (arb_ptr),
    .winner (arb_gnt)
  );

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    mux_sel_nx = mux_sel;
    grant_c    = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          mux_sel_nx = arb_gnt;
          state_nx   = LOCKED;
        end
      end
      LOCKED: begin
        // Non-owner reqs and the owner's own req are irrelevant here; only the tail releases.
        if (!out_stall && !rst) begin
          grant_c = mux_sel & valid_in;
        end
        if (|(grant_c & tail_in)) begin
          ptr_nx = rel_ptr;
`ifdef ALLOC_BACK2BACK_EN
          if (|req) begin
            mux_sel_nx = arb_gnt;
            state_nx   = LOCKED;
          end else begin
            mux_sel_nx = '0;
            state_nx   = IDLE;
          end
`else
          mux_sel_nx = '0;
          state_nx   = IDLE;
`endif
        end
      end
      default: begin
        state_nx   = IDLE;
        mux_sel_nx = '0;
      end
    endcase
  end

  assign grant     = grant_c;
  assign valid_out = |grant_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      mux_sel <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      mux_sel <= mux_sel_nx;
    end
  end

endmodule

// File: tb/tb_output_allocator_6.sv
// Self-checking bench for output_allocator_6 with a packet-level reference model.
module tb_output_allocator_6;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, valid_in, tail_in;
  logic         out_stall;
  logic [N-1:0] mux_sel, grant;
  logic         valid_out;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 when the output is free) and priority pointer.
  int m_owner = -1;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  output_allocator_6 #(.N_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .valid_in  (valid_in),
    .tail_in   (tail_in),
    .out_stall (out_stall),
    .mux_sel   (mux_sel),
    .grant     (grant),
    .valid_out (valid_out)
  );

  function automatic logic [N-1:0] oh(input int i);
    if (i < 0) return '0;
    return N'(1) << i;
  endfunction

  function automatic int m_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if ((r & oh(i)) != '0) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_mux();
    return oh(m_owner);
  endfunction

  function automatic logic [N-1:0] m_grant();
    if (rst || m_owner < 0 || out_stall) return '0;
    return valid_in & oh(m_owner);
  endfunction

  function automatic void m_step();
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (req != '0) m_owner = m_pick(req, m_ptr);
    end else if (m_grant() != '0 && (tail_in & oh(m_owner)) != '0) begin
      m_ptr = (m_owner + 1) % N;
`ifdef ALLOC_BACK2BACK_EN
      m_owner = (req != '0) ? m_pick(req, m_ptr) : -1;
`else
      m_owner = -1;
`endif
    end
  endfunction

  task automatic apply(input logic r, input logic [N-1:0] rq, input logic [N-1:0] v,
                       input logic [N-1:0] t, input logic s);
    @(negedge clk);
    rst       = r;
    req       = rq;
    valid_in  = v;
    tail_in   = t;
    out_stall = s;
    #1;
  endtask

  task automatic advance();
    m_step();
    @(posedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, '0, '0, '0, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b1, 6'b111111, 6'b111111, 6'b111111, 1'b0);
    checks++;
    if (grant !== 6'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs grant=%b valid_out=%b expected 000000/0", grant, valid_out);
    end
    checks++;
    if (mux_sel !== 6'b0) begin
      errors++;
      $display("FAIL reset_mux_sel got=%b expected 000000", mux_sel);
    end
    advance();
    apply(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b0 || grant !== 6'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle mux_sel=%b grant=%b valid_out=%b expected all zero", mux_sel, grant, valid_out);
    end
    advance();
  endtask

  task automatic test_basic();
    do_reset();
    apply(1'b0, 6'b000101, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b0) begin
      errors++;
      $display("FAIL basic_idle_mux got=%b expected 000000", mux_sel);
    end
    advance();
    apply(1'b0, '0, 6'b000001, 6'b000001, 1'b0);
    checks++;
    if (mux_sel !== 6'b000001) begin
      errors++;
      $display("FAIL basic_first_winner got=%b expected 000001", mux_sel);
    end
    checks++;
    if (grant !== 6'b000001 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_single_flit grant=%b valid_out=%b expected 000001/1", grant, valid_out);
    end
    advance();
    apply(1'b0, 6'b000101, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b0) begin
      errors++;
      $display("FAIL basic_released got=%b expected 000000", mux_sel);
    end
    advance();
    apply(1'b0, '0, 6'b000100, 6'b000100, 1'b0);
    checks++;
    if (mux_sel !== 6'b000100) begin
      errors++;
      $display("FAIL basic_ptr_advance got=%b expected 000100", mux_sel);
    end
    advance();
  endtask

  task automatic test_stall();
    logic st [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic tl [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int pulses = 0;
    do_reset();
    apply(1'b0, 6'b001000, '0, '0, 1'b0);
    advance();
    for (int c = 0; c < 7; c++) begin
      apply(1'b0, '0, 6'b001000, tl[c] ? 6'b001000 : 6'b000000, st[c]);
      checks++;
      if (mux_sel !== 6'b001000) begin
        errors++;
        $display("FAIL stall_mux_hold cyc=%0d got=%b expected 001000", c, mux_sel);
      end
      if (st[c]) begin
        checks++;
        if (grant !== 6'b0 || valid_out !== 1'b0) begin
          errors++;
          $display("FAIL stall_grant_low cyc=%0d grant=%b valid_out=%b expected 000000/0", c, grant, valid_out);
        end
      end
      if (valid_out === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL stall_pulse_count got=%0d expected 4", pulses);
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int when  [$];
    int gap;
`ifdef ALLOC_BACK2BACK_EN
    gap = 1;
`else
    gap = 2;
`endif
    do_reset();
    for (int c = 0; c < 14; c++) begin
      apply(1'b0, 6'b111111, 6'b111111, 6'b111111, 1'b0);
      checks++;
      if (grant !== m_grant()) begin
        errors++;
        $display("FAIL rr_grant cyc=%0d got=%b expected %b", c, grant, m_grant());
      end
      for (int i = 0; i < N; i++) begin
        if (grant === oh(i)) begin
          order.push_back(i);
          when.push_back(c);
        end
      end
      advance();
    end
    checks++;
    if (order.size() < 7) begin
      errors++;
      $display("FAIL rr_grant_count got=%0d expected at least 7", order.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (order[k] != (k % N)) begin
          errors++;
          $display("FAIL rr_order idx=%0d got=%0d expected %0d", k, order[k], k % N);
        end
        if (k > 0) begin
          checks++;
          if (when[k] - when[k-1] != gap) begin
            errors++;
            $display("FAIL rr_spacing idx=%0d got=%0d expected %0d", k, when[k] - when[k-1], gap);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1'b0, 6'b010000, '0, '0, 1'b0);
    advance();
    apply(1'b0, '0, 6'b010000, '0, 1'b0);
    checks++;
    if (grant !== 6'b010000) begin
      errors++;
      $display("FAIL rstmid_first_flit got=%b expected 010000", grant);
    end
    advance();
    apply(1'b1, '0, 6'b010000, '0, 1'b0);
    checks++;
    if (grant !== 6'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during grant=%b valid_out=%b expected 000000/0", grant, valid_out);
    end
    advance();
    apply(1'b0, 6'b111111, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b0 || grant !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_after mux_sel=%b grant=%b expected 000000/000000", mux_sel, grant);
    end
    advance();
    apply(1'b0, '0, 6'b000001, 6'b000001, 1'b0);
    checks++;
    if (mux_sel !== 6'b000001) begin
      errors++;
      $display("FAIL rstmid_ptr_restart got=%b expected 000001", mux_sel);
    end
    advance();
  endtask

  task automatic test_req_drop();
    do_reset();
    apply(1'b0, 6'b000010, '0, '0, 1'b0);
    advance();
    apply(1'b0, 6'b100000, 6'b000010, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b000010 || grant !== 6'b000010) begin
      errors++;
      $display("FAIL drop_owner_flit mux_sel=%b grant=%b expected 000010/000010", mux_sel, grant);
    end
    advance();
    apply(1'b0, 6'b100000, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b000010) begin
      errors++;
      $display("FAIL drop_hold got=%b expected 000010", mux_sel);
    end
    advance();
    apply(1'b0, 6'b100000, 6'b000010, 6'b000010, 1'b0);
    checks++;
    if (mux_sel !== 6'b000010 || grant !== 6'b000010) begin
      errors++;
      $display("FAIL drop_tail mux_sel=%b grant=%b expected 000010/000010", mux_sel, grant);
    end
    advance();
`ifndef ALLOC_BACK2BACK_EN
    apply(1'b0, 6'b100000, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b0) begin
      errors++;
      $display("FAIL drop_bubble got=%b expected 000000", mux_sel);
    end
    advance();
`endif
    apply(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b100000) begin
      errors++;
      $display("FAIL drop_new_owner got=%b expected 100000", mux_sel);
    end
    advance();
    apply(1'b0, '0, 6'b100000, 6'b100000, 1'b0);
    advance();
  endtask

  task automatic test_bubbles();
    do_reset();
    apply(1'b0, 6'b000100, '0, '0, 1'b0);
    advance();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, '0, '0, 6'b000100, 1'b0);
      checks++;
      if (valid_out !== 1'b0 || mux_sel !== 6'b000100) begin
        errors++;
        $display("FAIL bubble cyc=%0d valid_out=%b mux_sel=%b expected 0/000100", c, valid_out, mux_sel);
      end
      advance();
    end
    apply(1'b0, '0, 6'b000100, 6'b000100, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || grant !== 6'b000100) begin
      errors++;
      $display("FAIL bubble_tail valid_out=%b grant=%b expected 1/000100", valid_out, grant);
    end
    advance();
    apply(1'b0, '0, '0, '0, 1'b0);
    checks++;
    if (mux_sel !== 6'b0) begin
      errors++;
      $display("FAIL bubble_release got=%b expected 000000", mux_sel);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      apply($urandom_range(0, 39) == 0,
            N'($urandom),
            N'($urandom),
            N'($urandom) & N'($urandom),
            $urandom_range(0, 3) == 0);
      checks++;
      if (grant !== m_grant() || valid_out !== (m_grant() != '0)) begin
        errors++;
        $display("FAIL rand_grant cyc=%0d grant=%b valid_out=%b expected %b", c, grant, valid_out, m_grant());
      end
      checks++;
      if (mux_sel !== m_mux()) begin
        errors++;
        $display("FAIL rand_mux_sel cyc=%0d got=%b expected %b", c, mux_sel, m_mux());
      end
      advance();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    valid_in  = '0;
    tail_in   = '0;
    out_stall = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_round_robin();
    test_reset_mid();
    test_req_drop();
    test_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_allocator_6.md
OUTPUT_ALLOCATOR_6 -- requirements
Module: output_allocator_6

Interface
REQ-001 The block SHALL have one parameter: N_IN, default 6, number of switch input ports competing for this output port.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The port req SHALL be an input, N_IN bits wide: bit i high means input i holds a head flit routed to this output.
REQ-005 The port valid_in SHALL be an input, N_IN bits wide: bit i high means input i presents a valid flit.
REQ-006 The port tail_in SHALL be an input, N_IN bits wide: bit i high means the flit on input i is a tail flit.
REQ-007 The port out_stall SHALL be an input, 1 bit wide: downstream output buffer full, so no transfer is allowed.
REQ-008 The port mux_sel SHALL be an output, N_IN bits wide: a registered one-hot crossbar select that drives the output multiplexer; all-zero selects nothing.
REQ-009 The port grant SHALL be an output, N_IN bits wide: a one-hot flit-pop strobe to input i for the cycle's transfer.
REQ-010 The port valid_out SHALL be an output, 1 bit wide: a flit is transferred to the output this cycle.

Function
REQ-011 The block SHALL implement a two-state FSM with the states IDLE and LOCKED.
REQ-012 In IDLE with req nonzero, the block SHALL pick the winner round-robin, searching from ptr upward with wrap, then register mux_sel as the winner's one-hot and enter LOCKED; latency is 1 cycle from req to mux_sel.
REQ-013 In IDLE, grant, valid_out and mux_sel SHALL all be 0.
REQ-014 In LOCKED with owner g, the block SHALL drive grant[g] = valid_out = valid_in[g] & ~out_stall combinationally; all other grant bits are 0.
REQ-015 The block SHALL hold mux_sel constant throughout LOCKED, so a packet is never interleaved with another input.
REQ-016 On a LOCKED transfer with tail_in[g]=1, the block SHALL release the output: ptr <= (g+1) mod N_IN, and the next state follows REQ-023.
REQ-017 A single-flit packet (head=tail) SHALL need exactly one transfer to release.
REQ-018 The block SHALL update ptr only on release; a denied requester becomes highest priority after the owner releases.
REQ-019 While out_stall=1 or valid_in[g]=0 in LOCKED, the block SHALL leave the state, ptr and mux_sel unchanged.
REQ-020 The block SHALL ignore req bits of non-owners while LOCKED.
REQ-021 The block SHALL ignore a req drop by the owner mid-packet; only a tail transfer releases.

Reset
REQ-022 When rst=1 on a clock edge, the block SHALL set state=IDLE, ptr=0 and mux_sel=0, with grant=0 and valid_out=0 in the same cycle; reset during LOCKED abandons the packet with no release transfer.

Configuration
REQ-023 The block SHALL support the macro ALLOC_BACK2BACK_EN: when defined, a tail transfer re-arbitrates in the same cycle using the updated pointer (g+1) and excluding nothing, loading the new mux_sel and staying LOCKED if req is nonzero, else going to IDLE; when undefined, a tail transfer always goes to IDLE, costing one bubble cycle per packet.

Structure
REQ-024 The shared package alloc_pkg SHALL hold the N_IN default, the state typedef (IDLE, LOCKED) and the one-hot width constant.
REQ-025 Round-robin selection SHALL be one sub-module, rr_arbiter, which is purely combinational: inputs req and ptr, output one-hot winner.

Verification
REQ-026 The bench SHALL cover: reset, then req=6'b000101 with ptr=0 -> mux_sel=6'b000001 one cycle later; after tail, ptr=1, so the next packet goes to input 2.
REQ-027 The bench SHALL cover: a 4-flit packet from input 3 with out_stall asserted on flit 2 for 3 cycles -> grant[3] low during the stall, mux_sel=6'b001000 held, exactly 4 valid_out pulses.
REQ-028 The bench SHALL cover: all six inputs requesting continuously with single-flit packets -> grants in the order 0,1,2,3,4,5,0; with the macro defined, one grant per cycle; without it, one grant every 2 cycles.
REQ-029 The bench SHALL cover: rst asserted in the middle of a packet from input 4 -> next cycle mux_sel=0 and grant=0; arbitration restarts from ptr=0.
REQ-030 The bench SHALL cover: the owner's req dropped mid-packet and req=6'b100000 raised -> mux_sel unchanged until the owner's tail transfers, then mux_sel=6'b100000.
REQ-031 The bench SHALL cover: valid_in[g]=0 bubbles while LOCKED -> valid_out=0 in those cycles and no release.
